pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the CPU fetch stage. It drives the instruction address and advances by a fixed increment, or loads a new address on a branch, jump, call or return. It has a stall input and a configurable reset vector. It also contains an internal return-address stack (RAS), so subroutine call/return needs no memory traffic. It replaces the fixed 16-bit counter in the fetch path, and its output feeds instruction memory directly.

## Interface
Parameters:
- ADDR_W, 16: width of every address, in bits.
- RESET_VEC, 0: value loaded into pc_out on reset.
- INC, 1: step added per sequential advance (width ADDR_W).
- RAS_DEPTH, 4: number of return-address stack entries; must be at least 1.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: reset, synchronous, active-high.
- enable, input, 1: advance permitted; when low, all state holds (stall).
- branch_taken, input, 1: load branch_target.
- branch_target, input, ADDR_W: conditional branch destination.
- jump, input, 1: unconditional load of jump_target.
- call, input, 1: load jump_target and push the return address.
- jump_target, input, ADDR_W: destination for jump and call.
- ret, input, 1: load the popped return address.
- pc_out, output, ADDR_W: current instruction address (registered).
- pc_inc, output, ADDR_W: pc_out + INC, computed combinationally and truncated to ADDR_W.
- ras_count, output, clog2(RAS_DEPTH+1): number of valid stack entries.
- ras_empty, output, 1: high when ras_count == 0.
- ras_full, output, 1: high when ras_count == RAS_DEPTH.
- ras_err, output, 1: sticky flag for overflow or underflow; cleared only by reset.

## Operation
- Every control input is sampled on the rising edge of clk. There are no latches and no level-sensitive capture of targets.
- On reset:
  - pc_out = RESET_VEC.
  - ras_count = 0.
  - ras_err = 0.
  - Stack contents are don't-care.
- Reset overrides every other input.
- When enable = 0, pc_out, the stack and ras_err hold. All control inputs are ignored.
- When enable = 1, exactly one action is taken, chosen by priority (highest first):
  1. ret:
     - If the stack is not empty: pc_out <= top entry, then pop.
     - If the stack is empty: pc_out <= pc_inc, ras_err <= 1, stack unchanged.
  2. call:
     - pc_out <= jump_target, and pc_inc is pushed.
     - If the stack is full: the oldest entry is discarded and ras_err <= 1. The push still completes, so the stack acts as circular storage of the newest RAS_DEPTH addresses, and ras_count stays at RAS_DEPTH.
  3. jump: pc_out <= jump_target.
  4. branch_taken: pc_out <= branch_target.
  5. None of the above: pc_out <= pc_inc.
- Asserting ret and call together is a decode error. ret wins, the call is dropped with no push, and ras_err is not set for it.
- Arithmetic is modulo 2^ADDR_W. Increment past the top address wraps, for example 0xFFFF + 1 gives 0x0000 when ADDR_W = 16. Wrap is not an error.
- Stack pointer arithmetic wraps modulo RAS_DEPTH. RAS_DEPTH need not be a power of 2.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on pc_out after edge N and are stable for the whole cycle N+1.
- After reset is released, pc_out = RESET_VEC for the first cycle. The first enabled edge advances it.
- pc_inc follows pc_out combinationally in the same cycle.
- ras_count, ras_empty and ras_full update on the same edge as the push or pop that changes them.
- ras_err rises on the edge where the faulting call or ret is taken.
- Reset asserted in the middle of a call/ret sequence aborts it. The next cycle shows pc_out = RESET_VEC and an empty stack, regardless of enable.
- enable = 0 in the same cycle as reset has no effect; reset still applies.

## Test plan
- **Reset and sequential advance:** with defaults, reset 2 cycles, then enable = 1 for 4 cycles -> pc_out is 0, 1, 2, 3, 4. Then enable = 0 for 3 cycles -> pc_out holds at 4.
- **Wrap-around:** ADDR_W = 8, INC = 4, RESET_VEC = 0xF8, run 3 enabled cycles -> pc_out is 0xF8, 0xFC, 0x00, 0x04. ras_err stays 0.
- **Priority:** at pc_out = 0x10, assert jump (jump_target = 0x40) and branch_taken (branch_target = 0x80) together -> pc_out = 0x40. Next cycle, assert call and ret together with the stack empty -> pc_out = 0x41, ras_err = 1, ras_count = 0.
- **Nested call/return:** call 0x100 from 0x10, call 0x200 from 0x100, ret, ret -> pc_out is 0x100, 0x200, 0x101, 0x11. ras_count is 1, 2, 1, 0. ras_err = 0.
- **Overflow:** RAS_DEPTH = 2, three calls from 0x10, 0x20, 0x30, each to the next address -> ras_full = 1 and ras_err = 1 after the third call. Two rets return to 0x31 then 0x21, then ras_empty = 1.
- **Reset mid-sequence:** after two calls, assert reset with enable = 0 -> next cycle pc_out = RESET_VEC, ras_count = 0, ras_err = 0. A following ret sets ras_err = 1 and advances pc_out by INC.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// pc_out advances by INC or is loaded from a branch, jump, call or return target.
// A circular return-address stack holds the newest RAS_DEPTH return addresses.
// ras_err is sticky and records stack overflow or underflow.
module pc_unit #(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]  INC       = ADDR_W'(1),
  parameter int                 RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             branch_taken,
  input  logic [ADDR_W-1:0]                branch_target,
  input  logic                             jump,
  input  logic                             call,
  input  logic [ADDR_W-1:0]                jump_target,
  input  logic                             ret,
  output logic [ADDR_W-1:0]                pc_out,
  output logic [ADDR_W-1:0]                pc_inc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_empty,
  output logic                             ras_full,
  output logic                             ras_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(RAS_DEPTH);

  // Stack storage. wr_ptr is the next slot to write; the top entry sits one
  // slot below it. When the stack is full wr_ptr points at the oldest entry,
  // so a push simply overwrites it.
  logic [ADDR_W-1:0] stack_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  wr_ptr_inc;

  logic [ADDR_W-1:0] pc_next;
  logic              push;
  logic              pop;
  logic              err_set;

  assign pc_inc     = pc_out + INC;
  assign ras_empty  = (ras_count == '0);
  assign ras_full   = (ras_count == CNT_DEPTH);
  assign top_ptr    = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
  assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);

  // Select the single action for this cycle by priority: ret, call, jump, branch, advance.
  always_comb begin
    pc_next = pc_out;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (enable) begin
      if (ret) begin
        // A call asserted together with ret is dropped without a push.
        if (!ras_empty) begin
          pc_next = stack_mem[top_ptr];
          pop     = 1'b1;
        end else begin
          pc_next = pc_inc;
          err_set = 1'b1;
        end
      end else if (call) begin
        pc_next = jump_target;
        push    = 1'b1;
        err_set = ras_full;
      end else if (jump) begin
        pc_next = jump_target;
      end else if (branch_taken) begin
        pc_next = branch_target;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  // Program counter, stack pointer, entry count and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out    <= RESET_VEC;
      wr_ptr    <= '0;
      ras_count <= '0;
      ras_err   <= 1'b0;
    end else begin
      pc_out <= pc_next;
      if (push) begin
        wr_ptr <= wr_ptr_inc;
        if (!ras_full) ras_count <= ras_count + CNT_W'(1);
      end else if (pop) begin
        wr_ptr    <= top_ptr;
        ras_count <= ras_count - CNT_W'(1);
      end
      if (err_set) ras_err <= 1'b1;
    end
  end

  // Stack contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (!reset && push) stack_mem[wr_ptr] <= pc_inc;
  end

endmodule
